// File: rtl/multicycle_control_fsm.sv
// ============================================================================
// multicycle_control_fsm
//
// Control unit for a multicycle RISC-V style datapath with a single unified
// memory. The controller is a Moore machine that walks each instruction
// through fetch, decode and one or more execute/writeback states. All control
// outputs are decoded combinationally from the state register (plus the few
// inputs that qualify them), so there are no separate output registers.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   Op          in   [6:0] opcode from the instruction register
//   funct3      in   [2:0] instruction funct3
//   funct7b5    in   instruction bit 30 (selects sub for R-type)
//   Zero        in   ALU zero flag (branch resolution)
//   mem_ready   in   unified memory access completes this cycle
//   PCWrite     out  PC register write enable
//   AdrSrc      out  memory address select (0 = PC, 1 = ALU result reg)
//   IRWrite     out  instruction register write enable
//   MemWrite    out  memory write strobe
//   RegWrite    out  register file write enable
//   ResultSrc   out  [1:0] result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   ALUSrcA     out  [1:0] ALU A mux (00 PC, 01 OldPC, 10 RD1)
//   ALUSrcB     out  [1:0] ALU B mux (00 RD2, 01 Imm, 10 constant 4)
//   ImmSrc      out  [1:0] immediate format select
//   ALUControl  out  [2:0] ALU operation (000 add, 001 sub, 010 and,
//                         011 or, 101 slt)
//   instr_done  out  one-cycle pulse when an instruction retires
//   illegal     out  held high while parked on an unsupported opcode
// ============================================================================
//
// state     | meaning
// ----------+----------------------------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 once memory is ready
// DECODE    | register read, ALUOut <= OldPC + imm (branch/jump target)
// MEMADR    | ALUOut <= RD1 + imm (load/store address)
// MEMREAD   | read data memory, wait for mem_ready
// MEMWB     | write loaded data to rd
// MEMWRITE  | write RD2 to memory, strobe held until mem_ready
// EXECUTER  | register-register ALU op
// EXECUTEI  | register-immediate ALU op
// ALUWB     | write ALUOut to rd
// BEQ       | compare RD1/RD2, take branch target if equal
// JAL       | PC <= target, ALUOut <= OldPC + 4 for the link register
// TRAP      | unsupported opcode, parked until reset
// ============================================================================

module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t state;

    // Raw strobes before reset gating
    logic pc_write_raw;
    logic ir_write_raw;
    logic mem_write_raw;
    logic reg_write_raw;
    logic instr_done_raw;

    logic [2:0] alu_func;

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) state <= DECODE;
                end
                DECODE: begin
                    case (Op)
                        OP_LOAD,
                        OP_STORE:  state <= MEMADR;
                        OP_RTYPE:  state <= EXECUTER;
                        OP_ITYPE:  state <= EXECUTEI;
                        OP_BRANCH: state <= BEQ;
                        OP_JAL:    state <= JAL;
                        default:   state <= TRAP;
                    endcase
                end
                MEMADR: begin
                    state <= (Op == OP_LOAD) ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    if (mem_ready) state <= MEMWB;
                end
                MEMWB: begin
                    state <= FETCH;
                end
                MEMWRITE: begin
                    if (mem_ready) state <= FETCH;
                end
                EXECUTER,
                EXECUTEI: begin
                    state <= ALUWB;
                end
                ALUWB: begin
                    state <= FETCH;
                end
                BEQ: begin
                    state <= FETCH;
                end
                JAL: begin
                    // link value OldPC+4 is in ALUOut by the time ALUWB runs
                    state <= ALUWB;
                end
                TRAP: begin
                    state <= TRAP;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // ALU function for the execute states. The sub qualifier only applies to
    // register-register ops: for addi, bit 30 belongs to the immediate.
    // ------------------------------------------------------------------------
    always_comb begin
        alu_func = ALU_ADD;
        case (funct3)
            3'b000:  alu_func = ((Op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_func = ALU_SLT;
            3'b110:  alu_func = ALU_OR;
            3'b111:  alu_func = ALU_AND;
            default: alu_func = ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------------
    // Immediate format depends only on the opcode, independent of state
    // ------------------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        case (Op)
            OP_LOAD,
            OP_ITYPE:  ImmSrc = 2'b00;
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write_raw   = 1'b0;
        ir_write_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        reg_write_raw  = 1'b0;
        instr_done_raw = 1'b0;
        AdrSrc         = 1'b0;
        ResultSrc      = RES_ALUOUT;
        ALUSrcA        = SRCA_PC;
        ALUSrcB        = SRCB_RD2;
        ALUControl     = ALU_ADD;

        case (state)
            FETCH: begin
                AdrSrc       = 1'b0;
                ALUSrcA      = SRCA_PC;
                ALUSrcB      = SRCB_FOUR;
                ALUControl   = ALU_ADD;
                ResultSrc    = RES_ALURES;
                // PC and IR only latch once the fetch read has landed
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
            end
            DECODE: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            MEMREAD: begin
                AdrSrc    = 1'b1;
                ResultSrc = RES_ALUOUT;
            end
            MEMWB: begin
                ResultSrc      = RES_DATA;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc         = 1'b1;
                ResultSrc      = RES_ALUOUT;
                mem_write_raw  = 1'b1;
                instr_done_raw = mem_ready;
            end
            EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = alu_func;
            end
            EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_func;
            end
            ALUWB: begin
                ResultSrc      = RES_ALUOUT;
                reg_write_raw  = 1'b1;
                instr_done_raw = 1'b1;
            end
            BEQ: begin
                ALUSrcA        = SRCA_RD1;
                ALUSrcB        = SRCB_RD2;
                ALUControl     = ALU_SUB;
                ResultSrc      = RES_ALUOUT;
                pc_write_raw   = Zero;
                instr_done_raw = 1'b1;
            end
            JAL: begin
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                ALUControl   = ALU_ADD;
                ResultSrc    = RES_ALUOUT;
                pc_write_raw = 1'b1;
            end
            TRAP: begin
                // everything stays at its quiet default
            end
            default: begin
            end
        endcase
    end

    // Strobes are gated by rst directly so they drop the moment reset is
    // asserted, without waiting for the state register to settle.
    assign PCWrite    = rst & pc_write_raw;
    assign IRWrite    = rst & ir_write_raw;
    assign MemWrite   = rst & mem_write_raw;
    assign RegWrite   = rst & reg_write_raw;
    assign instr_done = rst & instr_done_raw;
    assign illegal    = rst & (state == TRAP);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done;
    logic       illegal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [17:0] obs;

    multicycle_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    assign obs = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // field order: pcw adr irw mw rw | rs sa sb imm | alu | done ill
    function automatic logic [17:0] sig(input logic pcw, input logic adr,
                                        input logic irw, input logic mw,
                                        input logic rw, input logic [1:0] rs,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] imm, input logic [2:0] alu,
                                        input logic dn, input logic il);
        return {pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, dn, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive qualifiers at the falling edge, sample shortly after
    task automatic cyc(input string tag, input logic mr, input logic z, input logic [17:0] exp);
        @(negedge clk);
        mem_ready = mr;
        Zero      = z;
        #1;
        chk(tag, {14'd0, obs}, {14'd0, exp});
    endtask

    // Four-cycle ALU instruction with mem_ready high throughout
    task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [1:0] exp_sb, input logic [2:0] exp_alu);
        Op       = op;
        funct3   = f3;
        funct7b5 = f7;
        cyc({tag, "_fetch"},  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0));
        cyc({tag, "_decode"}, 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0));
        cyc({tag, "_exec"},   1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b10,exp_sb,2'b00, exp_alu, 0,0));
        cyc({tag, "_aluwb"},  1'b1, 1'b0, sig(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1,0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        Op        = OP_RTYPE;
        funct3    = 3'b000;
        funct7b5  = 1'b1;
        Zero      = 1'b0;
        mem_ready = 1'b1;

        // Reset with mem_ready high: fetch selects visible, strobes forced low
        @(negedge clk);
        #1;
        chk("reset_outputs", {14'd0, obs},
            {14'd0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0)});
        @(negedge clk);
        #1;
        chk("reset_illegal", {31'd0, illegal}, 32'd0);

        @(posedge clk);
        #2 rst = 1'b1;

        // R-type sub, then other ALU decodes
        alu_instr("r_sub",  OP_RTYPE, 3'b000, 1'b1, 2'b00, 3'b001);
        alu_instr("r_slt",  OP_RTYPE, 3'b010, 1'b0, 2'b00, 3'b101);
        alu_instr("r_and",  OP_RTYPE, 3'b111, 1'b0, 2'b00, 3'b010);
        alu_instr("r_f3_1", OP_RTYPE, 3'b001, 1'b1, 2'b00, 3'b000);
        alu_instr("i_add",  OP_ITYPE, 3'b000, 1'b1, 2'b01, 3'b000);
        alu_instr("i_or",   OP_ITYPE, 3'b110, 1'b0, 2'b01, 3'b011);

        // Fetch stall: two wait cycles, then normal R-type
        Op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b0;
        cyc("fetch_stall0", 1'b0, 1'b0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0));
        cyc("fetch_stall1", 1'b0, 1'b0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0));
        alu_instr("r_add_after_stall", OP_RTYPE, 3'b000, 1'b0, 2'b00, 3'b000);

        // lw with two memory wait cycles: 7 cycles total
        Op = OP_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        cyc("lw_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0));
        cyc("lw_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0));
        cyc("lw_memadr", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 3'b000, 0,0));
        cyc("lw_read_w0", 1'b0, 1'b0, sig(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
        cyc("lw_read_w1", 1'b0, 1'b0, sig(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
        cyc("lw_read_ok", 1'b1, 1'b0, sig(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,0));
        cyc("lw_memwb",  1'b1, 1'b0, sig(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00, 3'b000, 1,0));

        // beq taken then not taken: 3 cycles each
        Op = OP_BRANCH; funct3 = 3'b000;
        cyc("beq1_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0,0));
        cyc("beq1_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0));
        cyc("beq1_taken",  1'b1, 1'b1, sig(1,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 1,0));
        cyc("beq2_fetch",  1'b1, 1'b1, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b10, 3'b000, 0,0));
        cyc("beq2_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b10, 3'b000, 0,0));
        cyc("beq2_nottkn", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 3'b001, 1,0));

        // sw with three wait cycles: MemWrite held four cycles, one done pulse
        Op = OP_STORE; funct3 = 3'b010;
        cyc("sw_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0));
        cyc("sw_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000, 0,0));
        cyc("sw_memadr", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0,0));
        for (int i = 0; i < 3; i++)
            cyc("sw_write_wait", 1'b0, 1'b0, sig(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,0));
        cyc("sw_write_ok", 1'b1, 1'b0, sig(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 1,0));

        // jal: 4 cycles, link written in ALUWB
        Op = OP_JAL; funct3 = 3'b000;
        cyc("jal_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b11, 3'b000, 0,0));
        cyc("jal_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b11, 3'b000, 0,0));
        cyc("jal_jump",   1'b1, 1'b0, sig(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b11, 3'b000, 0,0));
        cyc("jal_aluwb",  1'b1, 1'b0, sig(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b11, 3'b000, 1,0));

        // Illegal opcode: TRAP for 20 cycles regardless of inputs
        Op = OP_BAD; funct3 = 3'b000;
        cyc("trap_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0));
        cyc("trap_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 3'b000, 0,0));
        for (int i = 0; i < 20; i++)
            cyc("trap_hold", i[0], i[1], sig(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0,1));

        // Reset pulse out of TRAP
        mem_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        chk("trap_rst_outputs", {14'd0, obs},
            {14'd0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 3'b000, 0,0)});
        @(posedge clk);
        #2 rst = 1'b1;
        alu_instr("post_trap", OP_RTYPE, 3'b000, 1'b1, 2'b00, 3'b001);

        // Reset in the middle of a stalled store: MemWrite drops without a clock
        Op = OP_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
        cyc("sw2_fetch",  1'b1, 1'b0, sig(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0));
        cyc("sw2_decode", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b01, 3'b000, 0,0));
        cyc("sw2_memadr", 1'b1, 1'b0, sig(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b01, 3'b000, 0,0));
        cyc("sw2_write",  1'b0, 1'b0, sig(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b01, 3'b000, 0,0));
        #1 rst = 1'b0;
        #1;
        chk("rst_memwrite_drop", {31'd0, MemWrite}, 32'd0);
        chk("rst_memwrite_outputs", {14'd0, obs},
            {14'd0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0)});
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_hold_outputs", {14'd0, obs},
            {14'd0, sig(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b01, 3'b000, 0,0)});
        @(posedge clk);
        #2 rst = 1'b1;
        alu_instr("post_rst", OP_RTYPE, 3'b110, 1'b0, 2'b00, 3'b011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port Op, input, 7 bits: instruction opcode, taken from the instruction register.
REQ-004 SHALL have port funct3, input, 3 bits: instruction funct3.
REQ-005 SHALL have port funct7b5, input, 1 bit: instruction bit 30.
REQ-006 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: unified memory access completes this cycle.
REQ-008 SHALL have the following outputs, 1 bit each: PCWrite, AdrSrc (0=PC, 1=ALU result), IRWrite, MemWrite, RegWrite.
REQ-009 SHALL have the following outputs, 2 bits each: ResultSrc (00=ALUOut, 01=Data, 10=ALUResult), ALUSrcA (00=PC, 01=OldPC, 10=RD1), ALUSrcB (00=RD2, 01=Imm, 10=constant 4), ImmSrc.
REQ-010 SHALL have port ALUControl, output, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 SHALL have port instr_done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-012 SHALL have port illegal, output, 1 bit: sticky flag for an unsupported opcode.

Function
REQ-013 SHALL implement a Moore FSM with the following states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, TRAP.
REQ-014 SHALL decode all outputs from the state register and the inputs listed here, with no extra output registers.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU add, ResultSrc=10; IRWrite=PCWrite=mem_ready; the FSM stays in FETCH while mem_ready=0 and moves to DECODE when mem_ready=1.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALU add.
REQ-017 DECODE next state by Op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other value -> TRAP.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU add; next state MEMREAD if Op=0000011, else MEMWRITE.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; the FSM waits while mem_ready=0 and moves to MEMWB when mem_ready=1.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1, instr_done=1; next state FETCH.
REQ-021 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready=1; on mem_ready=1, instr_done=1 and next state FETCH.
REQ-022 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU function decoded per REQ-027; next state ALUWB.
REQ-023 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU function decoded per REQ-027; next state ALUWB.
REQ-024 ALUWB: ResultSrc=00, RegWrite=1, instr_done=1; next state FETCH.
REQ-025 BEQ: ALUSrcA=10, ALUSrcB=00, ALU sub, ResultSrc=00, PCWrite=Zero, instr_done=1; next state FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, ALU add, ResultSrc=00, PCWrite=1; next state ALUWB, which writes PC+4 to rd.
REQ-027 ALU function decode by funct3: 000 -> sub if (Op=0110011 and funct7b5=1), else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-028 ImmSrc SHALL be decoded from Op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other value -> 00.
REQ-029 Any output not listed for a state SHALL be 0.
REQ-030 TRAP: all write strobes 0, illegal=1; the FSM stays in TRAP until reset.
REQ-031 Cycle counts with mem_ready tied to 1: lw 5 cycles; sw 4; R-type and I-type 4; beq 3; jal 4.
REQ-032 Each added mem_ready=0 cycle SHALL extend FETCH, MEMREAD or MEMWRITE by exactly one cycle.

Reset
REQ-033 While rst=0: state=FETCH, illegal=0, and PCWrite, IRWrite, MemWrite, RegWrite, instr_done forced to 0 regardless of mem_ready.
REQ-034 Reset assertion in any state, including mid-instruction or in TRAP, SHALL abort the instruction with no write strobe in the cycles that follow.
REQ-035 After rst deasserts, the first rising edge SHALL evaluate FETCH.

Verification
REQ-036 Reset release, mem_ready=1, Op=0110011, funct3=000, funct7b5=1 -> states FETCH,DECODE,EXECUTER,ALUWB; ALUControl=001 in EXECUTER; RegWrite=1 and instr_done=1 only in ALUWB.
REQ-037 Op=0000011 with mem_ready=0 for 2 cycles in MEMREAD -> total 7 cycles; ResultSrc=01 and RegWrite=1 in MEMWB only.
REQ-038 Op=1100011, Zero=1 then repeated with Zero=0 -> PCWrite=1 in BEQ for the first run, 0 for the second; 3 cycles each; ImmSrc=10.
REQ-039 Op=0100011, mem_ready low 3 cycles in MEMWRITE -> MemWrite held 1 for 4 cycles; AdrSrc=1; instr_done pulses once.
REQ-040 Op=1111111 -> TRAP after DECODE; illegal=1; no write strobes for 20 cycles; rst pulse low -> illegal=0, state FETCH.
REQ-041 rst asserted during MEMWRITE with mem_ready=0 -> MemWrite drops to 0 asynchronously, before the next clock edge; next instruction fetch is normal.
